aq_djpeg_mcu_sequencer: RTL and testbench
=========================================

# aq_djpeg_mcu_sequencer

Parametrised MCU/block sequencer sitting between the stream front end and the Huffman decoder in the baseline JPEG decode path. It tracks the current component, the sub-block inside the MCU and the MCU X/Y position, handling subsampled luma and 1–MAXCOMP components. It adds restart-interval (DRI) handling with a request/acknowledge handshake and DC-predictor reset. It gates compressed-data enable while a restart is pending or after the frame has finished.

## Interface
Parameters:
- BW, 12: width of MCU X/Y coordinates and MCU dimension inputs.
- MAXCOMP, 3: maximum supported component count. Legal range is 1..4.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- ProcessInit  in  1  synchronous frame restart; clears all state.
- JpegComp  in  3  component count, 1..MAXCOMP; static while running.
- SubSamplingW  in  2  luma horizontal factor, 1 or 2 (0 treated as 1).
- SubSamplingH  in  2  luma vertical factor, 1 or 2 (0 treated as 1).
- JpegMcuWidth  in  BW  MCUs per row, ≥1.
- JpegMcuHeight  in  BW  MCU rows, ≥1.
- RestartInterval  in  16  MCUs per restart interval; 0 disables restarts.
- DataInEnable  in  1  raw enable from the bitstream front end.
- BlockDone  in  1  one-cycle pulse: decoder finished the current 8x8 block.
- RestartAck  in  1  one-cycle pulse: RSTn marker consumed.
- HmInEnable  out  1  DataInEnable & state==RUN.
- BlockColor  out  3  component of the current block.
- BlockSubX  out  1  luma sub-block column inside the MCU.
- BlockSubY  out  1  luma sub-block row inside the MCU.
- McuX  out  BW  current MCU column.
- McuY  out  BW  current MCU row.
- McuStart  out  1  current block is the first block of its MCU.
- RestartRequest  out  1  level; held from interval end until RestartAck.
- DcReset  out  1  one-cycle pulse; decoder clears DC predictors.
- DecodeFinish  out  1  level; last block of the frame done.
- Overrun  out  1  sticky; BlockDone arrived outside RUN.

## Operation
- States: RUN, RESTART, DONE. Reset and ProcessInit both enter RUN with all counters 0.
- Reset values: BlockColor, BlockSubX, BlockSubY, McuX, McuY = 0; McuStart = 1; RestartRequest, DcReset, DecodeFinish, Overrun = 0.
- Effective factors: Hs = (SubSamplingW==0) ? 1 : SubSamplingW; Vs likewise from SubSamplingH. If JpegComp==1, force Hs = Vs = 1 (non-interleaved scan).
- Block order in each MCU:
  - luma blocks first, in raster order: SubX increments, wraps at Hs, then SubY increments, up to Vs.
  - then one block each for components 1..JpegComp-1.
  - MCU length = Hs*Vs + JpegComp - 1.
- On BlockDone in RUN, when the block is the last in its MCU:
  - BlockColor, SubX and SubY return to 0.
  - McuX increments. At JpegMcuWidth-1 it wraps to 0 and McuY increments.
  - Restart counter increments.
- Frame end: last block of MCU (JpegMcuWidth-1, JpegMcuHeight-1) → DONE; DecodeFinish = 1. No restart request at frame end even if the interval coincides.
- Restart: an MCU completes with RestartInterval≠0, the counter reaches RestartInterval, and it is not the frame end → RESTART.
  - RestartRequest = 1 and the counter clears.
  - On RestartAck: RestartRequest = 0, DcReset pulses once, state returns to RUN.
- DcReset also pulses once on ProcessInit.
- BlockDone in RESTART or DONE is ignored, except that it sets Overrun.
- RestartAck outside RESTART is ignored.
- ProcessInit has priority over BlockDone and RestartAck in the same cycle.
- All arithmetic is unsigned; coordinates wrap only as described, with no overflow beyond JpegMcuWidth/Height.

## Timing
- All outputs are registered except HmInEnable, which is combinational from the registered state.
- BlockDone at edge n → position outputs and state are updated after edge n+1 (one-cycle latency).
- DecodeFinish and RestartRequest rise in the same cycle as the final position update.
- RestartAck at edge n → RestartRequest low and DcReset high after edge n+1. DcReset is high for exactly one cycle.
- HmInEnable is low for every cycle RestartRequest or DecodeFinish is high.
- Back-to-back BlockDone pulses, one per cycle, are supported.

## Test plan
- 4:2:0, 3 components, 2x1 MCUs, no DRI, 12 BlockDone pulses:
  - BlockColor sequence 0,0,0,0,1,2 per MCU.
  - SubX/SubY sequence 00,10,01,11.
  - McuX 0→1; DecodeFinish after the 12th pulse.
- 1 component with SubSampling=2/2, 3x2 MCUs: factors forced to 1; 6 pulses reach McuY=1, McuX=2; then DecodeFinish.
- 4:4:4, 4x1 MCUs, RestartInterval=2:
  - RestartRequest after pulse 6; HmInEnable low.
  - RestartAck → DcReset pulse.
  - No request at frame end after pulse 12.
- BlockDone during RESTART and after DONE: position unchanged; Overrun = 1 until ProcessInit.
- ProcessInit coincident with BlockDone mid-frame: all outputs return to reset values; DcReset pulses.
- Asynchronous reset asserted while in RESTART: RestartRequest falls immediately; state is RUN after release.

Source files
------------

// File: rtl/aq_djpeg_mcu_sequencer.sv
// Walks the baseline JPEG block order (luma sub-blocks, then chroma) across the MCU grid,
// inserting restart-marker handshakes every RestartInterval MCUs.
module aq_djpeg_mcu_sequencer #(
  parameter int unsigned BW      = 12,
  parameter int unsigned MAXCOMP = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ProcessInit,
  input  logic [2:0]    JpegComp,
  input  logic [1:0]    SubSamplingW,
  input  logic [1:0]    SubSamplingH,
  input  logic [BW-1:0] JpegMcuWidth,
  input  logic [BW-1:0] JpegMcuHeight,
  input  logic [15:0]   RestartInterval,
  input  logic          DataInEnable,
  input  logic          BlockDone,
  input  logic          RestartAck,
  output logic          HmInEnable,
  output logic [2:0]    BlockColor,
  output logic          BlockSubX,
  output logic          BlockSubY,
  output logic [BW-1:0] McuX,
  output logic [BW-1:0] McuY,
  output logic          McuStart,
  output logic          RestartRequest,
  output logic          DcReset,
  output logic          DecodeFinish,
  output logic          Overrun
);

  typedef enum logic [1:0] {RUN, RESTART, DONE} stateT;

  stateT       state;
  logic        doneQ;
  logic        ackQ;
  logic [15:0] rstCnt;

  logic [2:0]  compCnt;
  logic        hsTwo;
  logic        vsTwo;
  logic        lastSubX;
  logic        lastSubY;
  logic        lastInMcu;
  logic        lastCol;
  logic        frameEnd;
  logic [15:0] cntNext;

  // Effective geometry of the current MCU; a single-component scan is never interleaved.
  always_comb begin
    compCnt = JpegComp;
    if (JpegComp == 3'd0) compCnt = 3'd1;
    else if (JpegComp > 3'(MAXCOMP)) compCnt = 3'(MAXCOMP);
    hsTwo     = (compCnt != 3'd1) && SubSamplingW[1];
    vsTwo     = (compCnt != 3'd1) && SubSamplingH[1];
    lastSubX  = !hsTwo || BlockSubX;
    lastSubY  = !vsTwo || BlockSubY;
    lastInMcu = (BlockColor == 3'd0) ? (lastSubX && lastSubY && compCnt == 3'd1)
                                     : (BlockColor == 3'(compCnt - 3'd1));
    lastCol   = (McuX == BW'(JpegMcuWidth - BW'(1)));
    frameEnd  = lastCol && (McuY == BW'(JpegMcuHeight - BW'(1)));
    cntNext   = 16'(rstCnt + 16'd1);
  end

  assign HmInEnable = DataInEnable && (state == RUN);

  // BlockDone and RestartAck are registered once, giving the one-cycle update latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= RUN;
      doneQ          <= 1'b0;
      ackQ           <= 1'b0;
      rstCnt         <= '0;
      BlockColor     <= '0;
      BlockSubX      <= 1'b0;
      BlockSubY      <= 1'b0;
      McuX           <= '0;
      McuY           <= '0;
      McuStart       <= 1'b1;
      RestartRequest <= 1'b0;
      DcReset        <= 1'b0;
      DecodeFinish   <= 1'b0;
      Overrun        <= 1'b0;
    end else if (ProcessInit) begin
      state          <= RUN;
      doneQ          <= 1'b0;
      ackQ           <= 1'b0;
      rstCnt         <= '0;
      BlockColor     <= '0;
      BlockSubX      <= 1'b0;
      BlockSubY      <= 1'b0;
      McuX           <= '0;
      McuY           <= '0;
      McuStart       <= 1'b1;
      RestartRequest <= 1'b0;
      DcReset        <= 1'b1;
      DecodeFinish   <= 1'b0;
      Overrun        <= 1'b0;
    end else begin
      doneQ   <= BlockDone;
      ackQ    <= RestartAck;
      DcReset <= 1'b0;
      if (doneQ && state != RUN) Overrun <= 1'b1;
      case (state)
        RUN: begin
          if (doneQ) begin
            if (!lastInMcu) begin
              McuStart <= 1'b0;
              if (BlockColor != 3'd0) begin
                BlockColor <= 3'(BlockColor + 3'd1);
              end else if (!lastSubX) begin
                BlockSubX <= 1'b1;
              end else if (!lastSubY) begin
                BlockSubX <= 1'b0;
                BlockSubY <= 1'b1;
              end else begin
                BlockSubX  <= 1'b0;
                BlockSubY  <= 1'b0;
                BlockColor <= 3'd1;
              end
            end else begin
              BlockColor <= '0;
              BlockSubX  <= 1'b0;
              BlockSubY  <= 1'b0;
              McuStart   <= 1'b1;
              if (frameEnd) begin
                state        <= DONE;
                DecodeFinish <= 1'b1;
              end else begin
                McuX <= lastCol ? '0 : BW'(McuX + BW'(1));
                if (lastCol) McuY <= BW'(McuY + BW'(1));
                if (RestartInterval != 16'd0 && cntNext == RestartInterval) begin
                  state          <= RESTART;
                  RestartRequest <= 1'b1;
                  rstCnt         <= '0;
                end else begin
                  rstCnt <= cntNext;
                end
              end
            end
          end
        end
        RESTART: begin
          if (ackQ) begin
            state          <= RUN;
            RestartRequest <= 1'b0;
            DcReset        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aq_djpeg_mcu_sequencer.sv
// Scoreboard bench for aq_djpeg_mcu_sequencer: each BlockDone queues the expected position,
// a monitor compares two edges later.
module tb_aq_djpeg_mcu_sequencer;

  typedef struct packed {
    logic [2:0]  color;
    logic        subX;
    logic        subY;
    logic [11:0] mcuX;
    logic [11:0] mcuY;
    logic        start;
    logic        req;
    logic        fin;
    logic        ovr;
    logic        hm;
  } snapT;

  typedef struct packed {
    logic [2:0]  color;
    logic        subX;
    logic        subY;
    logic [11:0] mcuX;
    logic [11:0] mcuY;
  } posT;

  logic        clk = 1'b0;
  logic        rst;
  logic        ProcessInit;
  logic [2:0]  JpegComp;
  logic [1:0]  SubSamplingW;
  logic [1:0]  SubSamplingH;
  logic [11:0] JpegMcuWidth;
  logic [11:0] JpegMcuHeight;
  logic [15:0] RestartInterval;
  logic        DataInEnable;
  logic        BlockDone;
  logic        RestartAck;
  logic        HmInEnable;
  logic [2:0]  BlockColor;
  logic        BlockSubX;
  logic        BlockSubY;
  logic [11:0] McuX;
  logic [11:0] McuY;
  logic        McuStart;
  logic        RestartRequest;
  logic        DcReset;
  logic        DecodeFinish;
  logic        Overrun;

  aq_djpeg_mcu_sequencer #(.BW(12), .MAXCOMP(3)) dut (
    .clk(clk), .rst(rst), .ProcessInit(ProcessInit), .JpegComp(JpegComp),
    .SubSamplingW(SubSamplingW), .SubSamplingH(SubSamplingH),
    .JpegMcuWidth(JpegMcuWidth), .JpegMcuHeight(JpegMcuHeight),
    .RestartInterval(RestartInterval), .DataInEnable(DataInEnable),
    .BlockDone(BlockDone), .RestartAck(RestartAck), .HmInEnable(HmInEnable),
    .BlockColor(BlockColor), .BlockSubX(BlockSubX), .BlockSubY(BlockSubY),
    .McuX(McuX), .McuY(McuY), .McuStart(McuStart), .RestartRequest(RestartRequest),
    .DcReset(DcReset), .DecodeFinish(DecodeFinish), .Overrun(Overrun)
  );

  always #5 clk = ~clk;

  int   asserts = 0;
  int   fails   = 0;
  snapT expQ[$];
  posT  blk[$];
  snapT cur;
  int   mcuLen;
  int   riCfg;

  function automatic snapT resetSnap();
    snapT s = '0;
    s.start = 1'b1;
    s.hm    = 1'b1;
    return s;
  endfunction

  function automatic snapT actual();
    snapT s;
    s.color = BlockColor; s.subX = BlockSubX; s.subY = BlockSubY;
    s.mcuX = McuX; s.mcuY = McuY; s.start = McuStart; s.req = RestartRequest;
    s.fin = DecodeFinish; s.ovr = Overrun; s.hm = HmInEnable;
    return s;
  endfunction

  task automatic checkVal(input string nm, input logic [47:0] act, input logic [47:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Expected block order written out as plain nested loops over the frame.
  task automatic setup(input int comp, input int ssw, input int ssh, input int w, input int h,
                       input int ri, input int effHs, input int effVs);
    JpegComp = 3'(comp); SubSamplingW = 2'(ssw); SubSamplingH = 2'(ssh);
    JpegMcuWidth = 12'(w); JpegMcuHeight = 12'(h); RestartInterval = 16'(ri);
    riCfg  = ri;
    mcuLen = effHs * effVs + comp - 1;
    blk.delete();
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        for (int sy = 0; sy < effVs; sy++)
          for (int sx = 0; sx < effHs; sx++)
            blk.push_back('{3'd0, 1'(sx), 1'(sy), 12'(x), 12'(y)});
        for (int c = 1; c < comp; c++)
          blk.push_back('{3'(c), 1'b0, 1'b0, 12'(x), 12'(y)});
      end
  endtask

  function automatic snapT expAfter(input int k);
    snapT s = '0;
    posT  n;
    s.ovr = cur.ovr;
    if (k == blk.size() - 1) begin
      s.mcuX = blk[k].mcuX; s.mcuY = blk[k].mcuY;
      s.start = 1'b1; s.fin = 1'b1; s.hm = 1'b0;
    end else begin
      n = blk[k+1];
      s.color = n.color; s.subX = n.subX; s.subY = n.subY; s.mcuX = n.mcuX; s.mcuY = n.mcuY;
      s.start = (n.color == 3'd0) && !n.subX && !n.subY;
      s.req   = s.start && riCfg != 0 && (((k + 1) / mcuLen) % riCfg) == 0;
      s.hm    = !s.req;
    end
    return s;
  endfunction

  task automatic framePulses(input int first, input int last, input bit gap);
    for (int k = first; k <= last; k++) begin
      @(posedge clk); #1;
      BlockDone = 1'b1;
      cur = expAfter(k);
      expQ.push_back(cur);
      if (gap) begin @(posedge clk); #1; BlockDone = 1'b0; end
    end
    @(posedge clk); #1;
    BlockDone = 1'b0;
  endtask

  task automatic ignoredPulse();
    @(posedge clk); #1;
    BlockDone = 1'b1;
    cur.ovr = 1'b1;
    expQ.push_back(cur);
    @(posedge clk); #1;
    BlockDone = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() != 0 && n < 50) begin @(posedge clk); n++; end
    @(negedge clk);
    checkVal("sb_drain", 48'(expQ.size()), 48'd0);
  endtask

  task automatic processInit();
    @(posedge clk); #1;
    ProcessInit = 1'b1;
    @(posedge clk); #1;
    ProcessInit = 1'b0;
    cur = resetSnap();
    @(negedge clk);
    checkVal("init_dcreset", 48'(DcReset), 48'd1);
    checkVal("init_state", 48'(actual()), 48'(cur));
    @(negedge clk);
    checkVal("init_dcreset_low", 48'(DcReset), 48'd0);
  endtask

  // Monitor: a BlockDone sampled at edge n is checked after edge n+1.
  initial begin
    bit   pend = 1'b0;
    bit   chk;
    snapT e;
    forever begin
      @(posedge clk);
      chk  = pend;
      pend = BlockDone;
      if (chk) begin
        @(negedge clk);
        if (expQ.size() == 0) begin
          checkVal("sb_unexpected", 48'd1, 48'd0);
        end else begin
          e = expQ.pop_front();
          checkVal("sb_block", 48'(actual()), 48'(e));
        end
      end
    end
  end

  initial begin
    rst = 1'b0; ProcessInit = 1'b0; BlockDone = 1'b0; RestartAck = 1'b0; DataInEnable = 1'b1;
    setup(3, 2, 2, 2, 1, 0, 2, 2);
    cur = resetSnap();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkVal("reset_state", 48'(actual()), 48'(resetSnap()));
    checkVal("reset_dcreset", 48'(DcReset), 48'd0);

    // 4:2:0, three components, 2x1 MCUs, back-to-back pulses
    processInit();
    framePulses(0, 11, 1'b0);
    drain();

    // single component: subsampling forced to 1x1
    setup(1, 2, 2, 3, 2, 0, 1, 1);
    processInit();
    framePulses(0, 5, 1'b1);
    drain();

    // 4:4:4, 4x1 MCUs, restart every 2 MCUs
    setup(3, 1, 1, 4, 1, 2, 1, 1);
    processInit();
    framePulses(0, 5, 1'b0);
    drain();
    ignoredPulse();
    drain();
    @(posedge clk); #1;
    RestartAck = 1'b1;
    @(posedge clk); #1;
    RestartAck = 1'b0;
    @(negedge clk);
    checkVal("ack_req_held", 48'(RestartRequest), 48'd1);
    checkVal("ack_dc_early", 48'(DcReset), 48'd0);
    @(negedge clk);
    checkVal("ack_req_low", 48'(RestartRequest), 48'd0);
    checkVal("ack_dcreset", 48'(DcReset), 48'd1);
    checkVal("ack_hm_en", 48'(HmInEnable), 48'd1);
    @(negedge clk);
    checkVal("ack_dc_pulse", 48'(DcReset), 48'd0);
    cur.req = 1'b0;
    cur.hm  = 1'b1;
    framePulses(6, 11, 1'b1);
    drain();
    ignoredPulse();
    drain();
    processInit();
    checkVal("overrun_cleared", 48'(Overrun), 48'd0);

    // ProcessInit coincident with BlockDone mid-frame
    setup(3, 2, 2, 2, 1, 0, 2, 2);
    processInit();
    framePulses(0, 2, 1'b1);
    drain();
    @(posedge clk); #1;
    BlockDone = 1'b1; ProcessInit = 1'b1;
    cur = resetSnap();
    expQ.push_back(cur);
    @(posedge clk); #1;
    BlockDone = 1'b0; ProcessInit = 1'b0;
    @(negedge clk);
    checkVal("coinc_dcreset", 48'(DcReset), 48'd1);
    checkVal("coinc_state", 48'(actual()), 48'(cur));
    drain();

    // async reset while a restart is pending
    setup(3, 1, 1, 4, 1, 2, 1, 1);
    processInit();
    framePulses(0, 5, 1'b0);
    drain();
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checkVal("async_req_drop", 48'(RestartRequest), 48'd0);
    checkVal("async_state", 48'(actual()), 48'(resetSnap()));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkVal("async_run", 48'(actual()), 48'(resetSnap()));

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
